// File: rtl/cache_types_pkg.sv
// Shared field widths, line geometry and controller state encoding for the
// direct-mapped cache controller.
package cache_types_pkg;

   localparam int ADDR_W     = 32;
   localparam int TAG_W      = 23;
   localparam int SET_W      = 4;
   localparam int WORD_W     = 3;
   localparam int OFFSET_W   = 5;
   localparam int NUM_SETS   = 16;
   localparam int LINE_W     = 256;
   localparam int LINE_BYTES = LINE_W / 8;

   typedef enum logic [2:0] {
      IDLE,
      COMPARE,
      WRITEBACK,
      ALLOCATE,
      STALL
   } cache_state_t;

   // Turns a per-byte enable into a per-bit mask over a whole line.
   function automatic logic [LINE_W-1:0] expandMask(input logic [LINE_BYTES-1:0] byteMask);
      logic [LINE_W-1:0] bits;
      bits = '0;
      for (int i = 0; i < LINE_BYTES; i++) begin
         bits[i*8 +: 8] = {8{byteMask[i]}};
      end
      return bits;
   endfunction

endpackage

// File: rtl/cache_ctrl_fsm.sv
// State register and next-state logic of the cache controller; all
// datapath and SRAM/memory muxing is done by the parent.
module cache_ctrl_fsm
   import cache_types_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_request,
   input  logic         i_hit,
   input  logic         i_dirtyMiss,
   input  logic         i_memResp,
   output cache_state_t o_state
);

   cache_state_t r_state;
   cache_state_t w_nextState;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:      if (i_request) w_nextState = COMPARE;
         COMPARE: begin
            if (i_hit) begin
               w_nextState = IDLE;
            end else if (i_dirtyMiss) begin
               w_nextState = WRITEBACK;
            end else begin
               w_nextState = ALLOCATE;
            end
         end
         WRITEBACK: if (i_memResp) w_nextState = ALLOCATE;
         ALLOCATE:  if (i_memResp) w_nextState = STALL;
         STALL:     w_nextState = COMPARE;
         default:   w_nextState = IDLE;
      endcase
   end

   assign o_state = r_state;

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller: 16 sets of
// 32-byte lines, tag/data held in external SRAMs, valid/dirty in flops.
module cache_ctrl
   import cache_types_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     ufp_addr,
   input  logic [3:0]            ufp_rmask,
   input  logic [3:0]            ufp_wmask,
   input  logic [31:0]           ufp_wdata,
   output logic [31:0]           ufp_rdata,
   output logic                  ufp_resp,
   output logic [ADDR_W-1:0]     dfp_addr,
   output logic                  dfp_read,
   output logic                  dfp_write,
   output logic [LINE_W-1:0]     dfp_wdata,
   input  logic [LINE_W-1:0]     dfp_rdata,
   input  logic                  dfp_resp,
   output logic                  tag_csb,
   output logic                  tag_web,
   output logic [SET_W-1:0]      tag_addr,
   output logic [TAG_W-1:0]      tag_din,
   input  logic [TAG_W-1:0]      tag_dout,
   output logic                  data_csb,
   output logic                  data_web,
   output logic [SET_W-1:0]      data_addr,
   output logic [LINE_BYTES-1:0] data_wmask,
   output logic [LINE_W-1:0]     data_din,
   input  logic [LINE_W-1:0]     data_dout
);

   cache_state_t          w_state;
   logic [TAG_W-1:0]      w_tag;
   logic [SET_W-1:0]      w_set;
   logic [WORD_W-1:0]     w_word;
   logic [1:0]            w_unusedBits;
   logic                  w_request;
   logic                  w_isWrite;
   logic                  w_hit;
   logic                  w_dirtyMiss;
   logic [TAG_W-1:0]      w_tagEff;
   logic [LINE_W-1:0]     w_line;
   logic                  w_readIssue;
   logic                  w_dataWrite;
   logic                  w_tagWrite;

   logic [NUM_SETS-1:0]   r_valid;
   logic [NUM_SETS-1:0]   r_dirty;
   logic                  r_wrValid;
   logic                  r_tagWrValid;
   logic [SET_W-1:0]      r_wrSet;
   logic [LINE_BYTES-1:0] r_wrMask;
   logic [LINE_W-1:0]     r_wrData;
   logic [TAG_W-1:0]      r_wrTag;
   logic                  r_dataBypass;
   logic                  r_tagBypass;

   assign w_tag        = ufp_addr[31:9];
   assign w_set        = ufp_addr[8:5];
   assign w_word       = ufp_addr[4:2];
   assign w_unusedBits = ufp_addr[1:0];
   assign w_request    = (ufp_rmask | ufp_wmask) != 4'b0000;
   assign w_isWrite    = ufp_wmask != 4'b0000;

   // A lookup issued the cycle after an SRAM write may see pre-write contents,
   // so the last written tag/line is merged over what the SRAM returns.
   assign w_tagEff    = r_tagBypass ? r_wrTag : tag_dout;
   assign w_line      = r_dataBypass ? ((data_dout & ~expandMask(r_wrMask)) | (r_wrData & expandMask(r_wrMask)))
                                     : data_dout;
   assign w_hit       = r_valid[w_set] && (w_tagEff == w_tag);
   assign w_dirtyMiss = r_valid[w_set] && r_dirty[w_set];
   assign ufp_rdata   = w_line[{w_word, 5'b00000} +: 32];

   cache_ctrl_fsm u_fsm (
      .clk         (clk),
      .rst         (rst),
      .i_request   (w_request),
      .i_hit       (w_hit),
      .i_dirtyMiss (w_dirtyMiss),
      .i_memResp   (dfp_resp),
      .o_state     (w_state)
   );

   always_comb begin
      ufp_resp   = 1'b0;
      dfp_addr   = '0;
      dfp_read   = 1'b0;
      dfp_write  = 1'b0;
      dfp_wdata  = '0;
      tag_csb    = 1'b1;
      tag_web    = 1'b1;
      tag_addr   = w_set;
      tag_din    = w_tag;
      data_csb   = 1'b1;
      data_web   = 1'b1;
      data_addr  = w_set;
      data_wmask = '0;
      data_din   = {8{ufp_wdata}};
      if (!rst) begin
         case (w_state)
            IDLE: begin
               if (w_request) begin
                  tag_csb  = 1'b0;
                  data_csb = 1'b0;
               end
            end
            COMPARE: begin
               if (w_hit) begin
                  ufp_resp = 1'b1;
                  if (w_isWrite) begin
                     data_csb   = 1'b0;
                     data_web   = 1'b0;
                     data_wmask = LINE_BYTES'(ufp_wmask) << {w_word, 2'b00};
                  end
               end
            end
            WRITEBACK: begin
               dfp_write = 1'b1;
               dfp_addr  = {w_tagEff, w_set, 5'b00000};
               dfp_wdata = w_line;
            end
            ALLOCATE: begin
               dfp_read = 1'b1;
               dfp_addr = {w_tag, w_set, 5'b00000};
               if (dfp_resp) begin
                  tag_csb    = 1'b0;
                  tag_web    = 1'b0;
                  data_csb   = 1'b0;
                  data_web   = 1'b0;
                  data_wmask = '1;
                  data_din   = dfp_rdata;
               end
            end
            STALL: begin
               tag_csb  = 1'b0;
               data_csb = 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign w_readIssue = !tag_csb && tag_web;
   assign w_dataWrite = !data_csb && !data_web;
   assign w_tagWrite  = !tag_csb && !tag_web;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid      <= '0;
         r_dirty      <= '0;
         r_wrValid    <= 1'b0;
         r_tagWrValid <= 1'b0;
         r_dataBypass <= 1'b0;
         r_tagBypass  <= 1'b0;
      end else begin
         if (w_state == ALLOCATE && dfp_resp) begin
            r_valid[w_set] <= 1'b1;
            r_dirty[w_set] <= 1'b0;
         end else if (w_state == WRITEBACK && dfp_resp) begin
            r_dirty[w_set] <= 1'b0;
         end else if (w_dataWrite) begin
            r_dirty[w_set] <= 1'b1;
         end
         r_wrValid    <= w_dataWrite;
         r_tagWrValid <= w_tagWrite;
         if (w_readIssue) begin
            r_dataBypass <= r_wrValid && (r_wrSet == w_set);
            r_tagBypass  <= r_tagWrValid && (r_wrSet == w_set);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_dataWrite) begin
         r_wrSet  <= data_addr;
         r_wrMask <= data_wmask;
         r_wrData <= data_din;
      end
      if (w_tagWrite) begin
         r_wrTag <= tag_din;
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with behavioural tag/data SRAMs and a
// single-cycle backing memory whose lines follow a fixed address pattern.
module tb_cache_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  ufp_addr;
   logic [3:0]   ufp_rmask;
   logic [3:0]   ufp_wmask;
   logic [31:0]  ufp_wdata;
   logic [31:0]  ufp_rdata;
   logic         ufp_resp;
   logic [31:0]  dfp_addr;
   logic         dfp_read;
   logic         dfp_write;
   logic [255:0] dfp_wdata;
   logic [255:0] dfp_rdata;
   logic         dfp_resp;
   logic         tag_csb, tag_web;
   logic [3:0]   tag_addr;
   logic [22:0]  tag_din;
   logic [22:0]  tag_dout;
   logic         data_csb, data_web;
   logic [3:0]   data_addr;
   logic [31:0]  data_wmask;
   logic [255:0] data_din;
   logic [255:0] data_dout;

   int total = 0;
   int bad   = 0;
   logic memEnable;

   cache_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .ufp_addr   (ufp_addr),
      .ufp_rmask  (ufp_rmask),
      .ufp_wmask  (ufp_wmask),
      .ufp_wdata  (ufp_wdata),
      .ufp_rdata  (ufp_rdata),
      .ufp_resp   (ufp_resp),
      .dfp_addr   (dfp_addr),
      .dfp_read   (dfp_read),
      .dfp_write  (dfp_write),
      .dfp_wdata  (dfp_wdata),
      .dfp_rdata  (dfp_rdata),
      .dfp_resp   (dfp_resp),
      .tag_csb    (tag_csb),
      .tag_web    (tag_web),
      .tag_addr   (tag_addr),
      .tag_din    (tag_din),
      .tag_dout   (tag_dout),
      .data_csb   (data_csb),
      .data_web   (data_web),
      .data_addr  (data_addr),
      .data_wmask (data_wmask),
      .data_din   (data_din),
      .data_dout  (data_dout)
   );

   always #5 clk = ~clk;

   // Backing memory: word w of the line at address a is 0x1000_0000 + (a[10:5] << 8) + w.
   function automatic logic [255:0] lineFor(input logic [31:0] a);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) begin
         l[w*32 +: 32] = 32'h1000_0000 + (32'(a[10:5]) << 8) + 32'(w);
      end
      return l;
   endfunction

   assign dfp_rdata = lineFor(dfp_addr);
   assign dfp_resp  = memEnable & (dfp_read | dfp_write);

   // SRAM models: read data appears the cycle after the read; writes commit one edge late.
   logic [22:0]  tagMem  [0:15];
   logic [255:0] dataMem [0:15];
   logic         tagPend, dataPend;
   logic [3:0]   tagPendAddr, dataPendAddr;
   logic [22:0]  tagPendDin;
   logic [255:0] dataPendDin;
   logic [31:0]  dataPendMask;

   always @(posedge clk) begin
      if (tagPend) tagMem[tagPendAddr] <= tagPendDin;
      tagPend     <= rst ? 1'b0 : (!tag_csb && !tag_web);
      tagPendAddr <= tag_addr;
      tagPendDin  <= tag_din;
      if (!tag_csb && tag_web) tag_dout <= tagMem[tag_addr];
   end

   always @(posedge clk) begin
      if (dataPend) begin
         for (int b = 0; b < 32; b++) begin
            if (dataPendMask[b]) dataMem[dataPendAddr][b*8 +: 8] <= dataPendDin[b*8 +: 8];
         end
      end
      dataPend     <= rst ? 1'b0 : (!data_csb && !data_web);
      dataPendAddr <= data_addr;
      dataPendDin  <= data_din;
      dataPendMask <= data_wmask;
      if (!data_csb && data_web) data_dout <= dataMem[data_addr];
   end

   // Protocol monitor sampled mid-cycle.
   int   bothCount = 0;
   int   doubleResp = 0;
   int   leakCount = 0;
   int   respCount = 0;
   int   cycleCount = 0;
   logic prevResp = 1'b0;

   always @(negedge clk) begin
      if (dfp_read && dfp_write) bothCount <= bothCount + 1;
      if (ufp_resp && prevResp) doubleResp <= doubleResp + 1;
      if (!dfp_read && !dfp_write && (dfp_addr != 32'h0 || dfp_wdata != 256'h0)) leakCount <= leakCount + 1;
      if (ufp_resp) respCount <= respCount + 1;
      prevResp <= ufp_resp;
   end

   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Results of the most recent transaction.
   int           txCycles, txReadCycle, txWriteCycle;
   logic [31:0]  txRdata, txReadAddr, txWriteAddr;
   logic         txSawRead, txSawWrite;
   logic [255:0] txWriteData;

   // Drives one request starting just after a rising edge and returns just after
   // the edge that ends the response cycle; cycle 0 is the acceptance cycle.
   task automatic runTxn(input logic [31:0] addr, input logic [3:0] rmask,
                         input logic [3:0] wmask, input logic [31:0] wdata);
      logic done;
      ufp_addr  = addr;
      ufp_rmask = rmask;
      ufp_wmask = wmask;
      ufp_wdata = wdata;
      txCycles = 99; txReadCycle = 99; txWriteCycle = 99;
      txRdata = '0; txReadAddr = '0; txWriteAddr = '0; txWriteData = '0;
      txSawRead = 1'b0; txSawWrite = 1'b0;
      done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (dfp_read && !txSawRead) begin
            txSawRead = 1'b1; txReadAddr = dfp_addr; txReadCycle = k;
         end
         if (dfp_write && !txSawWrite) begin
            txSawWrite = 1'b1; txWriteAddr = dfp_addr; txWriteData = dfp_wdata; txWriteCycle = k;
         end
         if (ufp_resp) begin
            txCycles = k; txRdata = ufp_rdata; done = 1'b1;
         end
         @(posedge clk);
         #1;
         if (done) break;
      end
      ufp_rmask = 4'b0000;
      ufp_wmask = 4'b0000;
   endtask

   task automatic test_reset();
      rst = 1'b1; memEnable = 1'b1;
      ufp_addr = '0; ufp_rmask = '0; ufp_wmask = '0; ufp_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++; if (ufp_resp !== 1'b0) begin bad++; $display("[TB] FAIL reset_ufp_resp got=%b exp=0", ufp_resp); end
      total++; if ({dfp_read, dfp_write} !== 2'b00) begin bad++; $display("[TB] FAIL reset_dfp got=%b exp=00", {dfp_read, dfp_write}); end
      total++; if ({tag_csb, data_csb, tag_web, data_web} !== 4'b1111) begin bad++; $display("[TB] FAIL reset_sram_ctl got=%b exp=1111", {tag_csb, data_csb, tag_web, data_web}); end
      total++; if (dfp_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_dfp_addr got=%h exp=0", dfp_addr); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_clean_miss();
      runTxn(32'h0000_0040, 4'b1111, 4'b0000, 32'h0);
      total++; if (txCycles !== 4) begin bad++; $display("[TB] FAIL clean_miss_latency got=%0d exp=4", txCycles); end
      total++; if (txSawRead !== 1'b1 || txReadAddr !== 32'h0000_0040) begin bad++; $display("[TB] FAIL clean_miss_dfp_addr got=%b/%h exp=1/00000040", txSawRead, txReadAddr); end
      total++; if (txSawWrite !== 1'b0) begin bad++; $display("[TB] FAIL clean_miss_no_wb got=%b exp=0", txSawWrite); end
      total++; if (txRdata !== 32'h1000_0200) begin bad++; $display("[TB] FAIL clean_miss_rdata got=%h exp=10000200", txRdata); end
   endtask

   task automatic test_hit();
      runTxn(32'h0000_0040, 4'b1111, 4'b0000, 32'h0);
      total++; if (txCycles !== 1) begin bad++; $display("[TB] FAIL hit_latency got=%0d exp=1", txCycles); end
      total++; if (txSawRead !== 1'b0 || txSawWrite !== 1'b0) begin bad++; $display("[TB] FAIL hit_no_dfp got=%b%b exp=00", txSawRead, txSawWrite); end
      total++; if (txRdata !== 32'h1000_0200) begin bad++; $display("[TB] FAIL hit_rdata got=%h exp=10000200", txRdata); end
   endtask

   task automatic test_write_hit();
      runTxn(32'h0000_0044, 4'b0000, 4'b0011, 32'hDEAD_BEEF);
      total++; if (txCycles !== 1) begin bad++; $display("[TB] FAIL write_hit_latency got=%0d exp=1", txCycles); end
      total++; if (txSawRead !== 1'b0 || txSawWrite !== 1'b0) begin bad++; $display("[TB] FAIL write_hit_no_dfp got=%b%b exp=00", txSawRead, txSawWrite); end
      runTxn(32'h0000_0044, 4'b1111, 4'b0000, 32'h0);
      total++; if (txCycles !== 1) begin bad++; $display("[TB] FAIL read_after_write_latency got=%0d exp=1", txCycles); end
      total++; if (txRdata !== 32'h1000_BEEF) begin bad++; $display("[TB] FAIL read_after_write_rdata got=%h exp=1000beef", txRdata); end
   endtask

   task automatic test_dirty_evict();
      runTxn(32'h0000_0240, 4'b1111, 4'b0000, 32'h0);
      total++; if (txCycles !== 5) begin bad++; $display("[TB] FAIL dirty_miss_latency got=%0d exp=5", txCycles); end
      total++; if (txSawWrite !== 1'b1 || txWriteAddr !== 32'h0000_0040) begin bad++; $display("[TB] FAIL wb_addr got=%b/%h exp=1/00000040", txSawWrite, txWriteAddr); end
      total++; if (txWriteData[63:0] !== 64'h1000_BEEF_1000_0200) begin bad++; $display("[TB] FAIL wb_data_w1w0 got=%h exp=1000beef10000200", txWriteData[63:0]); end
      total++; if (txWriteData[95:64] !== 32'h1000_0202) begin bad++; $display("[TB] FAIL wb_data_w2 got=%h exp=10000202", txWriteData[95:64]); end
      total++; if (txSawRead !== 1'b1 || txReadAddr !== 32'h0000_0240) begin bad++; $display("[TB] FAIL refill_addr got=%b/%h exp=1/00000240", txSawRead, txReadAddr); end
      total++; if (txWriteCycle !== 2 || txReadCycle !== 3) begin bad++; $display("[TB] FAIL wb_then_refill_order got=%0d/%0d exp=2/3", txWriteCycle, txReadCycle); end
      total++; if (txRdata !== 32'h1000_1200) begin bad++; $display("[TB] FAIL evict_rdata got=%h exp=10001200", txRdata); end
   endtask

   task automatic test_mixed_mask();
      runTxn(32'h0000_0248, 4'b1111, 4'b1100, 32'h1234_5678);
      total++; if (txCycles !== 1) begin bad++; $display("[TB] FAIL mixed_latency got=%0d exp=1", txCycles); end
      runTxn(32'h0000_0248, 4'b1111, 4'b0000, 32'h0);
      total++; if (txRdata !== 32'h1234_1202) begin bad++; $display("[TB] FAIL mixed_is_write got=%h exp=12341202", txRdata); end
   endtask

   task automatic test_reset_mid_alloc();
      logic seen;
      memEnable = 1'b0;
      ufp_addr  = 32'h0000_0080;
      ufp_rmask = 4'b1111;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (dfp_read) begin
            seen = 1'b1;
            break;
         end
      end
      total++; if (seen !== 1'b1 || dfp_addr !== 32'h0000_0080) begin bad++; $display("[TB] FAIL alloc_reached got=%b/%h exp=1/00000080", seen, dfp_addr); end
      @(posedge clk);
      #1 rst = 1'b1; ufp_rmask = 4'b0000;
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++; if (dfp_read !== 1'b0) begin bad++; $display("[TB] FAIL reset_abandons_read got=%b exp=0", dfp_read); end
      @(posedge clk);
      #1 memEnable = 1'b1;
      runTxn(32'h0000_0040, 4'b1111, 4'b0000, 32'h0);
      total++; if (txCycles !== 4 || txSawRead !== 1'b1 || txSawWrite !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_clean_miss got=%0d/%b%b exp=4/10", txCycles, txSawRead, txSawWrite); end
      total++; if (txRdata !== 32'h1000_0200) begin bad++; $display("[TB] FAIL post_reset_rdata got=%h exp=10000200", txRdata); end
   endtask

   task automatic test_back_to_back();
      int startCycle, startResp, fails;
      logic [31:0] addr, expData;
      for (int s = 0; s < 16; s++) begin
         runTxn(32'(s) << 5, 4'b1111, 4'b0000, 32'h0);
      end
      startCycle = cycleCount;
      startResp  = respCount;
      fails = 0;
      for (int s = 0; s < 16; s++) begin
         addr    = (32'(s) << 5) + (32'(s % 8) << 2);
         expData = 32'h1000_0000 + (32'(s) << 8) + 32'(s % 8);
         runTxn(addr, 4'b1111, 4'b0000, 32'h0);
         total++; if (txCycles !== 1 || txRdata !== expData) begin bad++; $display("[TB] FAIL b2b_set%0d got=%0d/%h exp=1/%h", s, txCycles, txRdata, expData); end
      end
      total++; if (cycleCount - startCycle !== 32) begin bad++; $display("[TB] FAIL b2b_cycles got=%0d exp=32", cycleCount - startCycle); end
      total++; if (respCount - startResp !== 16) begin bad++; $display("[TB] FAIL b2b_resp_count got=%0d exp=16", respCount - startResp); end
   endtask

   task automatic test_protocol();
      total++; if (bothCount !== 0) begin bad++; $display("[TB] FAIL read_write_overlap got=%0d exp=0", bothCount); end
      total++; if (doubleResp !== 0) begin bad++; $display("[TB] FAIL resp_not_pulse got=%0d exp=0", doubleResp); end
      total++; if (leakCount !== 0) begin bad++; $display("[TB] FAIL dfp_idle_nonzero got=%0d exp=0", leakCount); end
   endtask

   initial begin
      test_reset();
      test_clean_miss();
      test_hit();
      test_write_hit();
      test_dirty_evict();
      test_mixed_mask();
      test_reset_mid_alloc();
      test_back_to_back();
      test_protocol();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
